lcd_frame_capture: RTL

- Consumes the PPU's LCD output stream (lcd_pixel, lcd_color, lcd_hsync, lcd_vsync).
- Maps each 2-bit color index through BGP to a 2-bit shade and packs 4 shades per byte.
- Writes bytes into a double-banked framebuffer through a valid/ready write port, buffered by a small FIFO.
- Swaps the displayed bank only after a clean, complete 160x144 frame. The downstream video scan-out reads the displayed bank.

---
 rtl/lcd_fb_pkg.sv | 28 ++
 rtl/sync_fifo_m.sv | 61 ++++++
 rtl/lcd_frame_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lcd_fb_pkg.sv
// Shared types, constants and helpers for the LCD frame capture path.
package lcd_fb_pkg;

    localparam int unsigned LINE_W        = 160;
    localparam int unsigned LINES         = 144;
    localparam int unsigned FB_LINE_BYTES = 40;
    localparam int unsigned BANK_BYTES    = 5760;

    // One framebuffer write: byte address plus four packed 2-bit shades.
    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } fb_wr_t;

    // Palette lookup: shade(c) = bgp[2c+1:2c].
    function automatic logic [1:0] shade_of(input logic [7:0] bgp, input logic [1:0] c);
        return bgp[{c, 1'b0} +: 2];
    endfunction

    // Byte address of pixel column x on line y in the given bank.
    function automatic logic [13:0] fb_addr_of(input logic bank, input logic [7:0] y,
                                               input logic [7:0] x);
        logic [13:0] base;
        base = bank ? 14'(BANK_BYTES) : 14'd0;
        return base + 14'(y) * 14'(FB_LINE_BYTES) + 14'(x >> 2);
    endfunction

endpackage

// File: rtl/sync_fifo_m.sv
// Generic single-clock FIFO; DEPTH must be a power of two.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo_m #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array; contents need no reset since reads are qualified by o_empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_capture.sv
// Captures the PPU LCD pixel stream into a double-banked 2bpp framebuffer.
// The displayed bank swaps only after a clean, complete frame.
module lcd_frame_capture
    import lcd_fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_pixel,
    input  logic [1:0]  lcd_color,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic [7:0]  bgp,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic        disp_bank,
    output logic        frame_done,
    output logic        err_overflow,
    output logic        err_line
);

    logic [7:0] r_x, w_x_d;
    logic [7:0] r_y, w_y_d;
    logic [5:0] r_acc, w_acc_d;
    logic       r_wbank, w_wbank_d;
    logic       r_disp_bank, w_disp_d;
    logic       r_frame_bad, w_bad_d;
    logic       r_frame_done;
    logic       r_err_overflow;
    logic       r_err_line;
    logic       r_hsync_prev;
    logic       r_vsync_prev;

    logic       w_hs_rise;
    logic       w_vs_rise;
    logic       w_pix_ok;
    logic       w_pix_bad;
    logic [1:0] w_shade;
    logic       w_line_short;
    logic [7:0] w_y_inc;
    logic [7:0] w_y_eff;
    logic       w_bad_now;
    logic       w_swap;
    logic       w_push;
    fb_wr_t     w_push_entry;
    fb_wr_t     w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_drop;

    assign w_hs_rise    = lcd_hsync & ~r_hsync_prev;
    assign w_vs_rise    = lcd_vsync & ~r_vsync_prev;
    assign w_pix_ok     = lcd_pixel & ~lcd_hsync & ~lcd_vsync &
                          (r_x < 8'(LINE_W)) & (r_y < 8'(LINES));
    assign w_pix_bad    = lcd_pixel & ~w_pix_ok;
    assign w_shade      = shade_of(bgp, lcd_color);
    assign w_line_short = w_hs_rise & (r_x != 8'(LINE_W));
    assign w_y_inc      = (r_y == 8'(LINES)) ? r_y : r_y + 8'd1;
    // A coincident line end is applied first, so the frame check sees the bumped y.
    assign w_y_eff      = w_hs_rise ? w_y_inc : r_y;

    assign w_pop        = ~w_empty & fb_ready;
    assign w_drop       = w_push & w_full & ~w_pop;
    assign w_bad_now    = r_frame_bad | w_pix_bad | w_line_short | w_drop;
    assign w_swap       = w_vs_rise & (w_y_eff == 8'(LINES)) & ~w_bad_now;

    // Select the byte to enqueue: a full group on its 4th pixel, or a padded partial at line end.
    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '0;
        if (w_pix_ok && (r_x[1:0] == 2'd3)) begin
            w_push            = 1'b1;
            w_push_entry.addr = fb_addr_of(r_wbank, r_y, r_x);
            w_push_entry.data = {r_acc, w_shade};
        end else if (w_hs_rise && (r_x[1:0] != 2'd0)) begin
            w_push            = 1'b1;
            w_push_entry.addr = fb_addr_of(r_wbank, r_y, r_x);
            unique case (r_x[1:0])
                2'd1:    w_push_entry.data = {r_acc[1:0], 6'd0};
                2'd2:    w_push_entry.data = {r_acc[3:0], 4'd0};
                default: w_push_entry.data = {r_acc, 2'd0};
            endcase
        end
    end

    // Next-state for position, accumulator, banks and frame health.
    always_comb begin
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_acc_d   = r_acc;
        w_wbank_d = r_wbank;
        w_disp_d  = r_disp_bank;
        w_bad_d   = w_bad_now;
        if (w_pix_ok) begin
            w_x_d   = r_x + 8'd1;
            w_acc_d = {r_acc[3:0], w_shade};
        end
        if (w_hs_rise) begin
            w_x_d   = '0;
            w_y_d   = w_y_inc;
            w_acc_d = '0;
        end
        if (w_vs_rise) begin
            w_x_d   = '0;
            w_y_d   = '0;
            w_acc_d = '0;
            w_bad_d = 1'b0;
            if (w_swap) begin
                w_disp_d  = r_wbank;
                w_wbank_d = ~r_wbank;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x            <= '0;
            r_y            <= '0;
            r_acc          <= '0;
            r_wbank        <= 1'b1;
            r_disp_bank    <= 1'b0;
            r_frame_bad    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_line     <= 1'b0;
            r_hsync_prev   <= 1'b0;
            r_vsync_prev   <= 1'b0;
        end else begin
            r_x            <= w_x_d;
            r_y            <= w_y_d;
            r_acc          <= w_acc_d;
            r_wbank        <= w_wbank_d;
            r_disp_bank    <= w_disp_d;
            r_frame_bad    <= w_bad_d;
            r_frame_done   <= w_swap;
            r_err_overflow <= r_err_overflow | w_drop;
            r_err_line     <= r_err_line | w_pix_bad | w_line_short;
            r_hsync_prev   <= lcd_hsync;
            r_vsync_prev   <= lcd_vsync;
        end
    end

    sync_fifo_m #(
        .WIDTH ($bits(fb_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push & ~w_drop),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign fb_valid     = ~w_empty;
    assign fb_addr      = w_empty ? 14'd0 : w_head.addr;
    assign fb_data      = w_empty ? 8'd0 : w_head.data;
    assign disp_bank    = r_disp_bank;
    assign frame_done   = r_frame_done;
    assign err_overflow = r_err_overflow;
    assign err_line     = r_err_line;

endmodule
